rob_commit_unit: RTL

ROB_COMMIT_UNIT -- requirements
Module: rob_commit_unit

---
 rtl/rob_commit_unit.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/rob_commit_unit.sv
// rob_commit_unit
//   Reorder buffer commit stage. A circular buffer of DEPTH entries tracks
//   in-flight instructions in program order. Entries are allocated at the tail
//   and completed out of order by writeback. They retire in order from the head,
//   at most one per cycle. Committing a mispredicted entry flushes the buffer
//   and raises a one-cycle redirect.
//
// Ports
//   clk, rst               clock; synchronous active-high reset
//   rdy                    global enable; when low, all state and outputs hold
//   alloc_valid/has_rd/rd  allocation request from decode
//   alloc_tag, full        tail index handed out as rename tag; buffer full
//   wb_*                   writeback of a result (and branch outcome) by tag
//   q1_*/q2_*              two operand lookup ports (pre-edge state)
//   commit_*               registered register-file write strobe and data
//   jump_wrong/redirect_pc registered flush pulse and corrected PC
module rob_commit_unit #(
  parameter int DEPTH = 16,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             alloc_valid,
  input  logic             alloc_has_rd,
  input  logic [4:0]       alloc_rd,
  output logic [TAG_W-1:0] alloc_tag,
  output logic             full,
  input  logic             wb_valid,
  input  logic [TAG_W-1:0] wb_tag,
  input  logic [31:0]      wb_value,
  input  logic             wb_mispredict,
  input  logic [31:0]      wb_target,
  input  logic [TAG_W-1:0] q1_tag,
  input  logic [TAG_W-1:0] q2_tag,
  output logic             q1_ready,
  output logic             q2_ready,
  output logic [31:0]      q1_value,
  output logic [31:0]      q2_value,
  output logic             commit_en,
  output logic [4:0]       commit_rd,
  output logic [TAG_W-1:0] commit_tag,
  output logic [31:0]      commit_value,
  output logic             jump_wrong,
  output logic [31:0]      redirect_pc
);

  logic [TAG_W-1:0] head_q;
  logic [TAG_W-1:0] tail_q;
  logic [TAG_W:0]   count_q;

  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] ready_q;
  logic [DEPTH-1:0] has_rd_q;
  logic [DEPTH-1:0] mis_q;
  logic [4:0]       rd_q     [DEPTH];
  logic [31:0]      value_q  [DEPTH];
  logic [31:0]      target_q [DEPTH];

  logic do_commit;
  logic do_flush;
  logic do_alloc;
  logic do_wb;
  logic [TAG_W-1:0] head_inc;
  logic [TAG_W-1:0] tail_inc;

  assign alloc_tag = tail_q;
  assign full      = (count_q == (TAG_W+1)'(DEPTH));

  // Lookups see only registered state; a same-cycle writeback is not bypassed.
  assign q1_ready = busy_q[q1_tag] && ready_q[q1_tag];
  assign q2_ready = busy_q[q2_tag] && ready_q[q2_tag];
  assign q1_value = value_q[q1_tag];
  assign q2_value = value_q[q2_tag];

  assign head_inc = (head_q == TAG_W'(DEPTH-1)) ? '0 : head_q + 1'b1;
  assign tail_inc = (tail_q == TAG_W'(DEPTH-1)) ? '0 : tail_q + 1'b1;

  // Commit decisions use pre-edge ready, so a writeback to the head entry
  // lands this cycle and the entry retires on the next one.
  assign do_commit = busy_q[head_q] && ready_q[head_q];
  assign do_flush  = do_commit && mis_q[head_q];
  // Full is judged on pre-edge count, so a same-cycle commit does not make room.
  // Nothing new is accepted on the flush edge or during the redirect pulse.
  assign do_alloc  = alloc_valid && !full && !jump_wrong && !do_flush;
  assign do_wb     = wb_valid && busy_q[wb_tag] && !jump_wrong && !do_flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      busy_q       <= '0;
      ready_q      <= '0;
      commit_en    <= 1'b0;
      commit_rd    <= '0;
      commit_tag   <= '0;
      commit_value <= '0;
      jump_wrong   <= 1'b0;
      redirect_pc  <= '0;
    end else if (rdy) begin
      commit_en  <= do_commit && has_rd_q[head_q];
      jump_wrong <= do_flush;
      if (do_commit) begin
        commit_rd    <= rd_q[head_q];
        commit_tag   <= head_q;
        commit_value <= value_q[head_q];
      end
      if (do_flush) begin
        redirect_pc <= target_q[head_q];
        busy_q      <= '0;
        ready_q     <= '0;
        head_q      <= '0;
        tail_q      <= '0;
        count_q     <= '0;
      end else begin
        if (do_wb) begin
          ready_q[wb_tag]  <= 1'b1;
          value_q[wb_tag]  <= wb_value;
          mis_q[wb_tag]    <= wb_mispredict;
          target_q[wb_tag] <= wb_target;
        end
        // Placed after the writeback so that retiring the head wins.
        if (do_commit) begin
          busy_q[head_q]  <= 1'b0;
          ready_q[head_q] <= 1'b0;
          head_q          <= head_inc;
        end
        // The tail entry is never busy when allocation is allowed, so it
        // cannot collide with the writeback or the commit above.
        if (do_alloc) begin
          busy_q[tail_q]   <= 1'b1;
          ready_q[tail_q]  <= 1'b0;
          mis_q[tail_q]    <= 1'b0;
          has_rd_q[tail_q] <= alloc_has_rd;
          rd_q[tail_q]     <= alloc_rd;
          tail_q           <= tail_inc;
        end
        count_q <= count_q + (TAG_W+1)'(do_alloc) - (TAG_W+1)'(do_commit);
      end
    end
  end

endmodule
